// File: rtl/des_round_sequencer.sv
// des_round_sequencer
//
// Iterative Feistel round controller for an iterative DES datapath. It holds
// the L/R halves of a post-IP block. Each RUN cycle it presents R (r_out) and
// a subkey index (key_idx) to the external round function. It then folds the
// combinational f result (f_in) back into the halves. After ROUNDS iterations
// the pre-output block {R_final, L_final} is registered onto block_out and
// flagged with a one-cycle done pulse.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      load block_in and begin (accepted only while idle)
//   decrypt    sampled with start; 1 = reverse subkey order
//   block_in   post-IP block, L0 = [63:32], R0 = [31:0]
//   f_in       round-function result for current r_out/key_idx
//   r_out      current R half
//   key_idx    subkey index for the current round
//   round_idx  current round counter, 0..ROUNDS-1
//   busy       high while a block is in flight (RUN, DONE)
//   done       one-cycle pulse when block_out becomes valid
//   block_out  {R_final, L_final}, held until the next accepted start
module des_round_sequencer #(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] block_in,
  input  logic [31:0] f_in,
  output logic [31:0] r_out,
  output logic [3:0]  key_idx,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done,
  output logic [63:0] block_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(ROUNDS - 1);

  state_t      state_q, state_d;
  logic [31:0] l_q, l_d;
  logic [31:0] r_q, r_d;
  logic [3:0]  rnd_q, rnd_d;
  logic        dec_q, dec_d;
  logic [63:0] bo_q, bo_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    rnd_d   = rnd_q;
    dec_d   = dec_q;
    bo_d    = bo_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          l_d     = block_in[63:32];
          r_d     = block_in[31:0];
          dec_d   = decrypt;
          rnd_d   = 4'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        l_d = r_q;
        r_d = l_q ^ f_in;
        // The counter parks at the last round so it never wraps.
        if (rnd_q == LAST) begin
          state_d = DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      DONE: begin
        // Final swap is undone by placing R (already R16) in the upper half.
        bo_d    = {r_q, l_q};
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      rnd_q   <= '0;
      dec_q   <= 1'b0;
      bo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      rnd_q   <= rnd_d;
      dec_q   <= dec_d;
      bo_q    <= bo_d;
      done_q  <= done_d;
    end
  end

  assign r_out     = r_q;
  assign round_idx = rnd_q;
  assign key_idx   = dec_q ? (LAST - rnd_q) : rnd_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign block_out = bo_q;

endmodule
